// File: rtl/filter_scheduler_if.sv
// Event port between the filter scheduler and its host: one filtered-level change per transfer.
interface filter_scheduler_if #(
  parameter int CH_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_chan;
  logic            evt_level;

  modport master (output evt_valid, evt_chan, evt_level, input evt_ready);
  modport slave  (input evt_valid, evt_chan, evt_level, output evt_ready);
endinterface

// File: rtl/filter_scheduler.sv
// Round-robin glitch filter shared across CHANNELS inputs; each filtered-level change is
// posted to the host as an event, with sticky overrun flags when a channel outruns the host.
module filter_scheduler #(
  parameter int CHANNELS = 4,
  parameter int CH_W     = $clog2(CHANNELS),
  parameter int CNT_W    = 3,
  parameter int THRESH   = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] sig_in,
  output logic [CHANNELS-1:0] sig_out,
  output logic [CHANNELS-1:0] overrun,
  input  logic [CHANNELS-1:0] ovr_clr,
  filter_scheduler_if.master  evt
);

  typedef enum logic {IDLE, OFFER} state_t;

  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(THRESH - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

  state_t              state_reg;
  logic [CH_W-1:0]     ch_idx_reg;
  logic [CH_W-1:0]     rr_ptr_reg;
  logic [CH_W-1:0]     evt_chan_reg;
  logic                evt_valid_reg;
  logic [CHANNELS-1:0] sig_out_reg;
  logic [CHANNELS-1:0] pending_reg;
  logic [CHANNELS-1:0] overrun_reg;

  logic [CHANNELS-1:0] flip;
  logic [CHANNELS-1:0] clear_vec;
  logic [CHANNELS-1:0] pending_next;
  logic [CHANNELS-1:0] overrun_next;
  logic [CH_W-1:0]     pick;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg;
      logic             visit;
      logic             differ;

      assign visit    = enable && (ch_idx_reg == CH_W'(gi));
      assign differ   = sig_in[gi] != sig_out_reg[gi];
      assign flip[gi] = visit && differ && (cnt_reg == CNT_TOP);

      // A matching sample on any visit discards accumulated progress.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else if (visit) begin
          if (!differ || flip[gi]) cnt_reg <= '0;
          else                     cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  // Delivery and a fresh flip in the same cycle: the new flip keeps the bit set without
  // counting as an overrun, since the earlier event did reach the host.
  always_comb begin
    clear_vec = '0;
    if (state_reg == OFFER && evt.evt_ready) clear_vec = CHANNELS'(1) << evt_chan_reg;
    pending_next = (pending_reg & ~clear_vec) | flip;
    overrun_next = (overrun_reg & ~ovr_clr) | (flip & pending_reg & ~clear_vec);
  end

  always_comb begin : pick_comb
    int  j;
    logic found;
    pick  = rr_ptr_reg;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      j = int'(rr_ptr_reg) + i;
      if (j >= CHANNELS) j = j - CHANNELS;
      if (!found && pending_reg[j]) begin
        pick  = CH_W'(j);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      ch_idx_reg    <= '0;
      rr_ptr_reg    <= '0;
      evt_chan_reg  <= '0;
      evt_valid_reg <= 1'b0;
      sig_out_reg   <= '0;
      pending_reg   <= '0;
      overrun_reg   <= '0;
    end else begin
      sig_out_reg <= sig_out_reg ^ flip;
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
      if (enable) ch_idx_reg <= (ch_idx_reg == CH_LAST) ? '0 : ch_idx_reg + CH_W'(1);

      case (state_reg)
        IDLE: begin
          if (|pending_reg) begin
            evt_chan_reg  <= pick;
            evt_valid_reg <= 1'b1;
            state_reg     <= OFFER;
          end
        end
        OFFER: begin
          if (evt.evt_ready) begin
            rr_ptr_reg    <= (evt_chan_reg == CH_LAST) ? '0 : evt_chan_reg + CH_W'(1);
            evt_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign sig_out       = sig_out_reg;
  assign overrun       = overrun_reg;
  assign evt.evt_valid = evt_valid_reg;
  assign evt.evt_chan  = evt_chan_reg;
  assign evt.evt_level = sig_out_reg[evt_chan_reg];

endmodule
